// File: rtl/inst_fetch_pkg.sv
// Shared widths, reset PC and the decode-queue entry type for the fetch unit.
package inst_fetch_pkg;

  localparam int ADDR_WIDTH = 16;
  localparam int DATA_WIDTH = 16;
  localparam int FIFO_DEPTH = 2;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC  = 16'h0000;
  localparam logic [DATA_WIDTH-1:0] INSTR_NOP = 16'h0000;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_WIDTH-1:0] pc_next(input logic [ADDR_WIDTH-1:0] pc);
    return pc + ADDR_WIDTH'(2);
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Memory, redirect and decode-side signals of the fetch unit, grouped for binding.
interface inst_fetch_if;
  import inst_fetch_pkg::*;

  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  imem_exc;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  // Decode handshake: a transfer happens on a posedge where dec_valid && dec_ready;
  // dec_valid/dec_instr/dec_pc hold stable until that transfer or a redirect flush.
  logic                  dec_valid;
  logic                  dec_ready;
  logic [DATA_WIDTH-1:0] dec_instr;
  logic [ADDR_WIDTH-1:0] dec_pc;
  logic                  fetch_fault;
  logic [ADDR_WIDTH-1:0] fault_pc;

  modport master (
    output imem_addr, dec_valid, dec_instr, dec_pc, fetch_fault, fault_pc,
    input  imem_data, imem_exc, redirect_valid, redirect_pc, dec_ready
  );

  modport slave (
    input  imem_addr, dec_valid, dec_instr, dec_pc, fetch_fault, fault_pc,
    output imem_data, imem_exc, redirect_valid, redirect_pc, dec_ready
  );

endinterface

// File: rtl/inst_fetch_fifo.sv
// Two-entry {instr,pc} decode queue; the parent's credit check keeps it from overflowing.
module inst_fetch_fifo
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  fetch_entry_t i_entry,
  input  logic         i_pop,
  input  logic         i_flush,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  // When full, push and pop share a slot: the head is read out this cycle before it is overwritten.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues PCs to a 1-cycle memory, queues responses for decode,
// and handles branch redirects and range/alignment faults.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_req_v;
  logic [ADDR_WIDTH-1:0] r_req_pc;
  logic                  r_fault;
  logic [ADDR_WIDTH-1:0] r_fault_pc;

  logic                  w_redirect;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_exc;
  logic                  w_issue;
  logic [1:0]            w_count;
  logic [2:0]            w_occ;
  fetch_entry_t          w_head;
  fetch_entry_t          w_entry;

  assign w_redirect = bus.redirect_valid;
  assign w_pop      = bus.dec_valid && bus.dec_ready;

  // Slots committed after this edge: queued entries plus the response in flight, minus the pop.
  assign w_occ   = {1'b0, w_count} + {2'b00, r_req_v} - {2'b00, w_pop};
  assign w_issue = !w_redirect && !r_fault && (w_occ < 3'd2);

  // Once faulted, any trailing response is discarded and the first fault PC is kept.
  assign w_push  = !w_redirect && r_req_v && !bus.imem_exc && !r_fault;
  assign w_exc   = !w_redirect && r_req_v &&  bus.imem_exc && !r_fault;

  assign w_entry = '{instr: bus.imem_data, pc: r_req_pc};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc       <= RESET_PC;
      r_req_v    <= 1'b0;
      r_req_pc   <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else if (w_redirect) begin
      r_pc    <= bus.redirect_pc;
      r_req_v <= 1'b0;
      r_fault <= bus.redirect_pc[0];
      if (bus.redirect_pc[0]) r_fault_pc <= bus.redirect_pc;
    end else begin
      if (w_issue) begin
        r_pc     <= pc_next(r_pc);
        r_req_v  <= 1'b1;
        r_req_pc <= r_pc;
      end else begin
        r_req_v  <= 1'b0;
      end
      if (w_exc) begin
        r_fault    <= 1'b1;
        r_fault_pc <= r_req_pc;
      end
    end
  end

  inst_fetch_fifo u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_entry (w_entry),
    .i_pop   (w_pop && !w_redirect),
    .i_flush (w_redirect),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_addr   = r_pc;
  assign bus.dec_valid   = (w_count != 2'd0);
  assign bus.dec_instr   = bus.dec_valid ? w_head.instr : '0;
  assign bus.dec_pc      = bus.dec_valid ? w_head.pc    : '0;
  assign bus.fetch_fault = r_fault;
  assign bus.fault_pc    = r_fault_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: byte memory model plus a queue-level reference of the fetch stream.
module tb_inst_fetch;
  import inst_fetch_pkg::*;

  localparam int MEM_SIZE = 4096;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  inst_fetch_if bus ();

  inst_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] mem [MEM_SIZE];

  function automatic logic addr_exc(input logic [15:0] a);
    return int'(a) > MEM_SIZE - 2;
  endfunction

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return {mem[int'(a) + 1], mem[int'(a)]};
  endfunction

  // Synchronous instruction memory, little-endian 16-bit words, 1-cycle latency.
  always @(posedge clk) begin
    if (addr_exc(bus.imem_addr)) begin
      bus.imem_exc  <= 1'b1;
      bus.imem_data <= 16'h0000;
    end else begin
      bus.imem_exc  <= 1'b0;
      bus.imem_data <= word_at(bus.imem_addr);
    end
  end

  // Reference: exp_q holds {instr,pc} the decoder should see, plus one optional fetch in flight.
  logic [31:0] exp_q [$];
  logic        m_inf_v;
  logic [15:0] m_inf_pc;
  logic [15:0] m_pc;
  logic        m_fault;
  logic [15:0] m_fault_pc;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_inf_v    = 1'b0;
    m_inf_pc   = RESET_PC;
    m_pc       = RESET_PC;
    m_fault    = 1'b0;
    m_fault_pc = 16'h0000;
  endtask

  task automatic model_update(input logic rv, input logic [15:0] rpc, input logic rdy);
    int   occ;
    logic pop;
    logic issue;
    pop = (exp_q.size() != 0) && rdy;
    if (rv) begin
      exp_q.delete();
      m_inf_v = 1'b0;
      m_pc    = rpc;
      m_fault = rpc[0];
      if (rpc[0]) m_fault_pc = rpc;
    end else begin
      occ   = exp_q.size() + (m_inf_v ? 1 : 0) - (pop ? 1 : 0);
      issue = !m_fault && (occ < FIFO_DEPTH);
      if (pop) void'(exp_q.pop_front());
      if (m_inf_v && !m_fault) begin
        if (addr_exc(m_inf_pc)) begin
          m_fault    = 1'b1;
          m_fault_pc = m_inf_pc;
        end else begin
          exp_q.push_back({word_at(m_inf_pc), m_inf_pc});
        end
      end
      if (issue) begin
        m_inf_v  = 1'b1;
        m_inf_pc = m_pc;
        m_pc     = m_pc + 16'd2;
      end else begin
        m_inf_v = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    logic [31:0] head;
    head = (exp_q.size() != 0) ? exp_q[0] : 32'h0;
    check_val("dec_valid",   bus.dec_valid, exp_q.size() != 0);
    check_val("dec_instr",   bus.dec_instr, head[31:16]);
    check_val("dec_pc",      bus.dec_pc, head[15:0]);
    check_val("imem_addr",   bus.imem_addr, m_pc);
    check_val("fetch_fault", bus.fetch_fault, m_fault);
    check_val("fault_pc",    bus.fault_pc, m_fault_pc);
  endtask

  // One clock: drive at negedge, advance the model at posedge, check at the next negedge.
  task automatic cycle(input logic rv, input logic [15:0] rpc, input logic rdy);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.dec_ready      = rdy;
    @(posedge clk);
    model_update(rv, rpc, rdy);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted between edges, released at the following negedge.
  task automatic pulse_reset();
    #2 rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    check_val("rst_valid", bus.dec_valid, 1'b0);
    check_val("rst_addr",  bus.imem_addr, RESET_PC);
    @(negedge clk);
    rst = 1'b1;
    compare_all();
  endtask

  initial begin
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.dec_ready      = 1'b0;
    for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    mem[4] = 8'h55; mem[5] = 8'h66; mem[6] = 8'h77; mem[7] = 8'h88;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    rst = 1'b1;

    // Streaming from reset at one instruction per cycle.
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t1_empty", bus.dec_valid, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t1_i0", bus.dec_instr, 16'h2211);
    check_val("t1_p0", bus.dec_pc, 16'h0000);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t1_i1", bus.dec_instr, 16'h4433);
    check_val("t1_p1", bus.dec_pc, 16'h0002);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t1_i2", bus.dec_instr, 16'h6655);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t1_i3", bus.dec_instr, 16'h8877);
    check_val("t1_p3", bus.dec_pc, 16'h0006);

    // Backpressure: queue holds 0 and 2, address parks at 4.
    pulse_reset();
    repeat (5) cycle(1'b0, 16'h0, 1'b0);
    check_val("t2_valid", bus.dec_valid, 1'b1);
    check_val("t2_head",  bus.dec_pc, 16'h0000);
    check_val("t2_addr",  bus.imem_addr, 16'h0004);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t2_p1", bus.dec_pc, 16'h0002);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t2_p2", bus.dec_pc, 16'h0004);

    // Redirect while the queue is full.
    repeat (3) cycle(1'b0, 16'h0, 1'b0);
    cycle(1'b1, 16'h0100, 1'b0);
    check_val("t3_flush", bus.dec_valid, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t3_gap", bus.dec_valid, 1'b0);
    cycle(1'b0, 16'h0, 1'b1);
    check_val("t3_pc", bus.dec_pc, 16'h0100);

    // Run off the end of memory: 0x0FFC, 0x0FFE deliver, 0x1000 faults.
    cycle(1'b1, 16'h0FFC, 1'b1);
    repeat (7) cycle(1'b0, 16'h0, 1'b1);
    check_val("t4_fault", bus.fetch_fault, 1'b1);
    check_val("t4_fpc",   bus.fault_pc, 16'h1000);
    check_val("t4_valid", bus.dec_valid, 1'b0);
    check_val("t4_addr",  bus.imem_addr, 16'h1004);
    cycle(1'b1, 16'h0000, 1'b1);
    check_val("t4_clear", bus.fetch_fault, 1'b0);
    repeat (2) cycle(1'b0, 16'h0, 1'b1);
    check_val("t4_resume", bus.dec_instr, 16'h2211);

    // Odd redirect target.
    cycle(1'b1, 16'h0011, 1'b1);
    check_val("t5_fault", bus.fetch_fault, 1'b1);
    check_val("t5_fpc",   bus.fault_pc, 16'h0011);
    repeat (3) cycle(1'b0, 16'h0, 1'b1);
    check_val("t5_valid", bus.dec_valid, 1'b0);

    // Reset in the middle of a stream.
    cycle(1'b1, 16'h0040, 1'b1);
    repeat (4) cycle(1'b0, 16'h0, 1'b1);
    pulse_reset();
    repeat (2) cycle(1'b0, 16'h0, 1'b1);
    check_val("t6_restart", bus.dec_pc, RESET_PC);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      logic        rv;
      logic [15:0] rpc;
      logic        rdy;
      int          sel;
      rv  = ($urandom_range(0, 19) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel <= 5)      rpc = 16'($urandom_range(0, MEM_SIZE - 2)) & 16'hFFFE;
      else if (sel <= 7) rpc = 16'($urandom_range(16'h0FE0, 16'h1010)) & 16'hFFFE;
      else if (sel == 8) rpc = 16'($urandom_range(0, MEM_SIZE - 2)) | 16'h0001;
      else               rpc = 16'($urandom);
      if ($urandom_range(0, 499) == 0) pulse_reset();
      else cycle(rv, rpc, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
